// File: rtl/lcd_cmd_host.sv
// Host-side command sequencer and IRAM write-back monitor for the display controller.
module lcd_cmd_host #(
  parameter int unsigned CMD_AW    = 6,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned FRAME_PIX = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CMD_AW:0]   num_cmds,
  output logic              crom_rd,
  output logic [CMD_AW-1:0] crom_A,
  input  logic [3:0]        crom_Q,
  output logic [3:0]        cmd,
  output logic              cmd_valid,
  input  logic              busy,
  input  logic              done,
  input  logic              IRAM_valid,
  input  logic [5:0]        IRAM_A,
  input  logic [7:0]        IRAM_D,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              err,
  output logic [7:0]        frame_cnt,
  output logic [15:0]       pix_cnt,
  output logic [15:0]       checksum
);

  localparam int unsigned CW = CMD_AW + 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, RDWAIT, READY, ISSUE, ACK, RELEASE, DONEW, NEXT, FIN
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [CW-1:0] idx;
  logic [CW-1:0] idx_nxt;
  logic [3:0]    cmd_hold;
  logic [WW-1:0] wait_cnt;
  logic [5:0]    exp_addr;
  logic          waiting;
  logic          wait_met;
  logic          timeout_hit;
  logic          start_acc;
  logic          addr_err;

  assign idx_nxt     = idx + CW'(1);
  assign waiting     = (state == READY) || (state == ACK) ||
                       (state == RELEASE) || (state == DONEW);
  assign timeout_hit = waiting && !wait_met && (wait_cnt == WW'(TIMEOUT - 1));
  assign start_acc   = (state == IDLE) && start;
  assign addr_err    = IRAM_valid && (IRAM_A != exp_addr);

  // Exit condition of whichever handshake phase is currently being waited on
  always_comb begin
    wait_met = 1'b0;
    case (state)
      READY:   wait_met = !busy;
      ACK:     wait_met = busy;
      RELEASE: wait_met = !busy;
      DONEW:   wait_met = done;
      default: wait_met = 1'b0;
    endcase
  end

  // Sequencer FSM with registered ROM, command and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      idx       <= '0;
      cmd_hold  <= '0;
      wait_cnt  <= '0;
      crom_rd   <= 1'b0;
      crom_A    <= '0;
      cmd       <= '0;
      cmd_valid <= 1'b0;
      seq_busy  <= 1'b0;
      seq_done  <= 1'b0;
    end else begin
      crom_rd   <= 1'b0;
      cmd_valid <= 1'b0;
      seq_done  <= 1'b0;
      wait_cnt  <= wait_cnt + WW'(1);
      if (timeout_hit) begin
        state    <= IDLE;
        seq_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (num_cmds == '0) begin
                seq_done <= 1'b1;
              end else begin
                count    <= num_cmds;
                idx      <= '0;
                crom_rd  <= 1'b1;
                crom_A   <= '0;
                seq_busy <= 1'b1;
                state    <= FETCH;
              end
            end
          end
          FETCH: state <= RDWAIT;
          RDWAIT: begin
            cmd_hold <= crom_Q;
            wait_cnt <= '0;
            // Codes C-F are reserved and silently skipped
            state    <= (crom_Q >= 4'hC) ? NEXT : READY;
          end
          READY: begin
            if (!busy) begin
              cmd       <= cmd_hold;
              cmd_valid <= 1'b1;
              state     <= ISSUE;
            end
          end
          ISSUE: begin
            wait_cnt <= '0;
            state    <= ACK;
          end
          ACK: begin
            if (busy) begin
              wait_cnt <= '0;
              state    <= (cmd_hold == 4'h0) ? DONEW : RELEASE;
            end
          end
          RELEASE: if (!busy) state <= NEXT;
          DONEW:   if (done) state <= NEXT;
          NEXT: begin
            idx <= idx_nxt;
            if (idx_nxt == count) begin
              seq_done <= 1'b1;
              state    <= FIN;
            end else begin
              crom_rd <= 1'b1;
              crom_A  <= idx_nxt[CMD_AW-1:0];
              state   <= FETCH;
            end
          end
          FIN: begin
            seq_busy <= 1'b0;
            state    <= IDLE;
          end
          default: begin
            seq_busy <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

  // Write-back monitor: pixel count, checksum, address order, frame count, sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt   <= '0;
      checksum  <= '0;
      exp_addr  <= '0;
      frame_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (IRAM_valid) begin
        pix_cnt  <= pix_cnt + 16'd1;
        checksum <= checksum + 16'(IRAM_D);
      end
      if (done) begin
        exp_addr  <= '0;
        frame_cnt <= frame_cnt + 8'd1;
      end else if (IRAM_valid) begin
        exp_addr <= (exp_addr == 6'(FRAME_PIX - 1)) ? 6'd0 : exp_addr + 6'd1;
      end
      err <= (err && !start_acc) || addr_err || timeout_hit;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Directed self-checking bench for lcd_cmd_host with a simple controller model.
module tb_lcd_cmd_host;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  num_cmds = '0;
  logic        crom_rd;
  logic [5:0]  crom_A;
  logic [3:0]  crom_Q = '0;
  logic [3:0]  cmd;
  logic        cmd_valid;
  logic        busy = 1'b0;
  logic        done = 1'b0;
  logic        IRAM_valid = 1'b0;
  logic [5:0]  IRAM_A = '0;
  logic [7:0]  IRAM_D = '0;
  logic        seq_busy, seq_done, err;
  logic [7:0]  frame_cnt;
  logic [15:0] pix_cnt, checksum;

  // Second instance with a short timeout and an unresponsive controller
  logic        start2 = 1'b0;
  logic [6:0]  num_cmds2 = 7'd1;
  logic        crom_rd2;
  logic [5:0]  crom_A2;
  logic [3:0]  crom_Q2 = '0;
  logic [3:0]  cmd2;
  logic        cmd_valid2, seq_busy2, seq_done2, err2;
  logic [7:0]  frame_cnt2;
  logic [15:0] pix_cnt2, checksum2;

  lcd_cmd_host dut (
    .clk(clk), .reset(reset), .start(start), .num_cmds(num_cmds),
    .crom_rd(crom_rd), .crom_A(crom_A), .crom_Q(crom_Q),
    .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
    .IRAM_valid(IRAM_valid), .IRAM_A(IRAM_A), .IRAM_D(IRAM_D),
    .seq_busy(seq_busy), .seq_done(seq_done), .err(err),
    .frame_cnt(frame_cnt), .pix_cnt(pix_cnt), .checksum(checksum)
  );

  lcd_cmd_host #(.CMD_AW(6), .TIMEOUT(16), .FRAME_PIX(64)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .num_cmds(num_cmds2),
    .crom_rd(crom_rd2), .crom_A(crom_A2), .crom_Q(crom_Q2),
    .cmd(cmd2), .cmd_valid(cmd_valid2), .busy(1'b0), .done(1'b0),
    .IRAM_valid(1'b0), .IRAM_A(6'd0), .IRAM_D(8'd0),
    .seq_busy(seq_busy2), .seq_done(seq_done2), .err(err2),
    .frame_cnt(frame_cnt2), .pix_cnt(pix_cnt2), .checksum(checksum2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [3:0] rom [64];
  always @(posedge clk) if (crom_rd) crom_Q <= rom[crom_A];
  always @(posedge clk) if (crom_rd2) crom_Q2 <= 4'h3;

  // Controller model and event recorder, all on the falling edge
  int         cyc = 0;
  int         vcount = 0;
  int         sd_count = 0;
  int         wide_cnt = 0;
  int         bcnt = 0;
  int         widx = 0;
  int         hold_until = 0;
  int         first_cv_cyc = 0;
  int         cv2_cyc = 0;
  int         err2_cyc = 0;
  int         cv2_count = 0;
  int         sd2_count = 0;
  bit         wr_pend = 0, wr_act = 0, done_nx = 0, prev_cv = 0, err2_prev = 0;
  bit         inject = 0;
  bit         first_seen = 0;
  logic [3:0] vlog [16];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      IRAM_valid = 1'b0;
      done = 1'b0;
      if (reset) begin
        busy = 1'b0; bcnt = 0; wr_pend = 0; wr_act = 0; done_nx = 0; widx = 0;
      end else begin
        if (done_nx) begin done = 1'b1; done_nx = 0; end
        if (wr_act) begin
          IRAM_valid = 1'b1;
          IRAM_A = (inject && widx == 4) ? 6'd5 : 6'(widx);
          IRAM_D = 8'(widx);
          widx++;
          if (widx == 64) begin wr_act = 0; done_nx = 1; end
        end
        if (cyc < hold_until) begin
          busy = 1'b1;
        end else if (bcnt > 0) begin
          bcnt--;
          if (bcnt == 0) begin
            busy = 1'b0;
            if (wr_pend) begin wr_pend = 0; wr_act = 1; widx = 0; end
          end
        end else if (cmd_valid) begin
          busy = 1'b1; bcnt = 2; wr_pend = (cmd == 4'h0);
        end else begin
          busy = 1'b0;
        end
      end
      if (cmd_valid) begin
        vlog[vcount % 16] = cmd;
        vcount++;
        if (!first_seen) begin first_seen = 1; first_cv_cyc = cyc; end
        if (prev_cv) wide_cnt++;
      end
      prev_cv = cmd_valid;
      if (seq_done) sd_count++;
      if (cmd_valid2) begin cv2_cyc = cyc; cv2_count++; end
      if (seq_done2) sd2_count++;
      if (err2 && !err2_prev) err2_cyc = cyc;
      err2_prev = err2;
    end
  end

  // Starts a sequence and waits for it to finish; reports activity deltas
  task automatic run_seq(input logic [6:0] n, input int hold, output int sd, output int nv,
                         output int v0, output int start_cyc, output bit tmo);
    int s0;
    s0 = sd_count;
    v0 = vcount;
    first_seen = 0;
    @(negedge clk);
    if (hold > 0) hold_until = cyc + hold;
    start_cyc = cyc;
    num_cmds = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tmo = 1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!seq_busy && !wr_act && !done_nx) begin tmo = 0; break; end
    end
    @(negedge clk);
    sd = sd_count - s0;
    nv = vcount - v0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cmd_valid, crom_rd, seq_busy, seq_done, err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {cmd_valid, crom_rd, seq_busy, seq_done, err});
    end
    n_cmp++;
    if ({frame_cnt, pix_cnt, checksum, crom_A, cmd} !== 50'd0) begin
      n_fail++; $display("FAIL reset_counts: got %h want 0", {frame_cnt, pix_cnt, checksum, crom_A, cmd});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int sd, nv, v0, sc, w0;
    bit tmo;
    rom[0] = 4'h1; rom[1] = 4'h5; rom[2] = 4'h0;
    w0 = wide_cnt;
    run_seq(7'd3, 0, sd, nv, v0, sc, tmo);
    n_cmp++;
    if (tmo) begin n_fail++; $display("FAIL basic_timeout: sequence did not finish"); end
    n_cmp++;
    if (nv != 3) begin n_fail++; $display("FAIL basic_nvalid: got %0d want 3", nv); end
    n_cmp++;
    if ({vlog[v0 % 16], vlog[(v0 + 1) % 16], vlog[(v0 + 2) % 16]} !== 12'h150) begin
      n_fail++; $display("FAIL basic_cmds: got %h want 150", {vlog[v0 % 16], vlog[(v0 + 1) % 16], vlog[(v0 + 2) % 16]});
    end
    n_cmp++;
    if (wide_cnt != w0) begin n_fail++; $display("FAIL basic_pulse_width: got %0d wide cycles want 0", wide_cnt - w0); end
    n_cmp++;
    if (pix_cnt !== 16'd64) begin n_fail++; $display("FAIL basic_pix: got %0d want 64", pix_cnt); end
    n_cmp++;
    if (checksum !== 16'd2016) begin n_fail++; $display("FAIL basic_checksum: got %0d want 2016", checksum); end
    n_cmp++;
    if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL basic_frames: got %0d want 1", frame_cnt); end
    n_cmp++;
    if (sd != 1) begin n_fail++; $display("FAIL basic_seq_done: got %0d want 1", sd); end
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", err); end
  endtask

  task automatic test_zero();
    int sd, nv, v0, sc;
    bit tmo;
    run_seq(7'd0, 0, sd, nv, v0, sc, tmo);
    n_cmp++;
    if (sd != 1 || nv != 0) begin n_fail++; $display("FAIL zero_cmds: got done=%0d valid=%0d want 1 0", sd, nv); end
  endtask

  task automatic test_busy_hold();
    int sd, nv, v0, sc;
    bit tmo;
    rom[0] = 4'h3;
    run_seq(7'd1, 70, sd, nv, v0, sc, tmo);
    n_cmp++;
    if (nv != 1 || vlog[v0 % 16] !== 4'h3) begin
      n_fail++; $display("FAIL hold_cmd: got n=%0d cmd=%h want 1 3", nv, vlog[v0 % 16]);
    end
    n_cmp++;
    if (first_cv_cyc - sc < 70 || first_cv_cyc - sc > 75) begin
      n_fail++; $display("FAIL hold_delay: got %0d want 70..75", first_cv_cyc - sc);
    end
    n_cmp++;
    if (sd != 1 || err !== 1'b0) begin n_fail++; $display("FAIL hold_done: got done=%0d err=%b want 1 0", sd, err); end
  endtask

  task automatic test_reserved();
    int sd, nv, v0, sc;
    bit tmo;
    rom[0] = 4'hC; rom[1] = 4'h9;
    run_seq(7'd2, 0, sd, nv, v0, sc, tmo);
    n_cmp++;
    if (nv != 1 || vlog[v0 % 16] !== 4'h9) begin
      n_fail++; $display("FAIL reserved_skip: got n=%0d cmd=%h want 1 9", nv, vlog[v0 % 16]);
    end
    n_cmp++;
    if (sd != 1 || err !== 1'b0) begin n_fail++; $display("FAIL reserved_done: got done=%0d err=%b want 1 0", sd, err); end
  endtask

  task automatic test_addr_err();
    int sd, nv, v0, sc;
    bit tmo;
    rom[0] = 4'h0;
    inject = 1;
    run_seq(7'd1, 0, sd, nv, v0, sc, tmo);
    inject = 0;
    n_cmp++;
    if (err !== 1'b1 || sd != 1) begin n_fail++; $display("FAIL addr_err: got err=%b done=%0d want 1 1", err, sd); end
    n_cmp++;
    if (pix_cnt !== 16'd128 || checksum !== 16'd4032 || frame_cnt !== 8'd2) begin
      n_fail++; $display("FAIL addr_counts: got %0d %0d %0d want 128 4032 2", pix_cnt, checksum, frame_cnt);
    end
    rom[0] = 4'h2;
    run_seq(7'd1, 0, sd, nv, v0, sc, tmo);
    n_cmp++;
    if (err !== 1'b0 || nv != 1) begin n_fail++; $display("FAIL addr_clear: got err=%b n=%0d want 0 1", err, nv); end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (err2) break;
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (err2 !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", err2); end
    n_cmp++;
    if (err2_cyc - cv2_cyc != 17 || cv2_count != 1) begin
      n_fail++; $display("FAIL timeout_cycle: got delta=%0d n=%0d want 17 1", err2_cyc - cv2_cyc, cv2_count);
    end
    n_cmp++;
    if (seq_busy2 !== 1'b0 || sd2_count != 0) begin
      n_fail++; $display("FAIL timeout_idle: got busy=%b done=%0d want 0 0", seq_busy2, sd2_count);
    end
  endtask

  task automatic test_reset_mid();
    int sd, nv, v0, sc;
    bit tmo;
    rom[0] = 4'h0;
    @(negedge clk);
    num_cmds = 7'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tmo = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_act && widx > 10) begin tmo = 0; break; end
    end
    n_cmp++;
    if (tmo || seq_busy !== 1'b1) begin n_fail++; $display("FAIL mid_reach_donew: got busy=%b want 1", seq_busy); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({cmd_valid, seq_busy, seq_done, err, crom_rd} !== 5'b0 || {frame_cnt, pix_cnt, checksum, crom_A, cmd} !== 50'd0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %b %h want 0 0", {cmd_valid, seq_busy, seq_done, err, crom_rd},
                         {frame_cnt, pix_cnt, checksum, crom_A, cmd});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rom[0] = 4'h2;
    run_seq(7'd1, 0, sd, nv, v0, sc, tmo);
    n_cmp++;
    if (nv != 1 || vlog[v0 % 16] !== 4'h2 || sd != 1 || err !== 1'b0 || pix_cnt !== 16'd0) begin
      n_fail++; $display("FAIL mid_rerun: got n=%0d cmd=%h done=%0d err=%b pix=%0d want 1 2 1 0 0",
                         nv, vlog[v0 % 16], sd, err, pix_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 4'h0;
    test_reset();
    test_basic();
    test_zero();
    test_busy_hold();
    test_reserved();
    test_addr_err();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
